lsu_dmem_master: RTL and testbench
==================================

LSU_DMEM_MASTER -- requirements
Module: lsu_dmem_master

Interface
REQ-001 The block SHALL have parameter nbits, default 32, data/address width; only 32 is supported.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-low.
REQ-004 Port req_valid  input  1  core load/store request.
REQ-005 Port req_ready  output  1  block can accept a request.
REQ-006 Port req_we  input  1  1=store, 0=load.
REQ-007 Port req_size  input  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 Port req_unsigned  input  1  zero-extend loads (lbu/lhu).
REQ-009 Port req_addr  input  nbits  byte address.
REQ-010 Port req_wdata  input  nbits  store data, right-aligned.
REQ-011 Port resp_valid  output  1  one-cycle completion pulse.
REQ-012 Port resp_rdata  output  nbits  extended load data.
REQ-013 Port resp_err  output  1  misaligned or illegal-size access, qualified by resp_valid.
REQ-014 Port proc_req  output  1  memory request.
REQ-015 Port mem_rdy  input  1  memory accepts the request this cycle.
REQ-016 Port addr  output  nbits  word address to memory, addr[1:0]=00.
REQ-017 Port wen  output  1  1=read, 0=write.
REQ-018 Port op2mem  output  nbits  full write word.
REQ-019 Port ddata  input  nbits  read data, qualified by valid.
REQ-020 Port valid  input  1  memory completion, for both reads and writes.

Function
REQ-021 The FSM SHALL have states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and ERR; only one transaction is outstanding at a time.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid=1 and req_ready=1, and its fields are registered at acceptance.
REQ-023 Misaligned (half with addr[0]=1, word with addr[1:0]!=00) or size 11: IDLE->ERR, no memory access; ERR->IDLE with resp_valid=1, resp_err=1, resp_rdata=0.
REQ-024 Load: IDLE->RD_REQ->RD_WAIT; on valid, ->IDLE, with resp_valid asserted the following cycle.
REQ-025 Word store: IDLE->WR_REQ->WR_WAIT; on valid, ->IDLE, with resp_valid asserted the following cycle and resp_rdata=0.
REQ-026 Byte/half store (read-modify-write): RD_REQ->RD_WAIT; on valid, merge the lane into the read word, then WR_REQ->WR_WAIT->IDLE, with resp_valid asserted the following cycle.
REQ-027 proc_req SHALL be 1 exactly in RD_REQ and WR_REQ; in RD_REQ wen=1; in WR_REQ wen=0.
REQ-028 addr, wen and op2mem SHALL be held stable while proc_req=1 until mem_rdy=1; the *_REQ->*_WAIT transition occurs on proc_req&&mem_rdy.
REQ-029 Byte lane SHALL be addr[1:0]*8 and half lane addr[1]*16; loads sign-extend unless req_unsigned=1.
REQ-030 valid received outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-031 resp_valid and resp_err SHALL be registered, single-cycle pulses; resp_rdata SHALL hold its value until the next response.
REQ-032 Minimum latency, with mem_rdy=1 and valid one cycle after acceptance: load or word store, acceptance at T -> resp_valid at T+3; sub-word store -> T+5.

Reset
REQ-033 When rst=0, the block SHALL go to IDLE immediately; proc_req=0, wen=1, addr=0, op2mem=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1 once rst=1.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no response; a late valid is ignored by REQ-030.

Structure
REQ-035 Package lsu_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W), the FSM state enum and the WEN_READ/WEN_WRITE constants.
REQ-036 Combinational lane extract/extend and store merge SHALL live in sub-module lsu_align; the FSM and registers SHALL live in lsu_dmem_master.

Verification
REQ-037 lb addr 0x103, mem word 0x80FF_1234 -> addr=0x100, wen=1, resp_rdata=0xFFFF_FF80; lbu -> 0x0000_0080.
REQ-038 sw addr 0x200, wdata 0xDEAD_BEEF, mem_rdy low for 3 cycles -> proc_req held 3+1 cycles with stable addr/op2mem, then wen=0, resp_valid once.
REQ-039 sh addr 0x202, wdata 0x0000_ABCD, old word 0x1111_2222 -> read then write op2mem=0xABCD_2222, resp_valid at T+5.
REQ-040 lw addr 0x101 -> no proc_req, resp_valid=1, resp_err=1 at T+2.
REQ-041 rst=0 in RD_WAIT, then valid arrives -> no resp_valid, state IDLE, req_ready=1 after rst=1.
REQ-042 Back-to-back lh 0x0 / lhu 0x2 on word 0x8001_7FFF -> resp_rdata 0x0000_7FFF then 0x0000_8001; req_ready=0 between.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lsu_pkg : shared encodings for the LSU data-memory master        |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic WEN_READ  = 1'b1;
    localparam logic WEN_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        ERR     = 3'd5
    } lsu_state_e;

    // Size 11 is reserved, so it is treated like a misaligned access.
    function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dmem_master_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lsu_dmem_master_if : core request/response and memory bus        |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
interface lsu_dmem_master_if #(
    parameter int nbits = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [nbits-1:0] req_addr;
    logic [nbits-1:0] req_wdata;
    logic             resp_valid;
    logic [nbits-1:0] resp_rdata;
    logic             resp_err;
    logic             proc_req;
    logic             mem_rdy;
    logic [nbits-1:0] addr;
    logic             wen;
    logic [nbits-1:0] op2mem;
    logic [nbits-1:0] ddata;
    logic             valid;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdy, ddata, valid,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output proc_req, addr, wen, op2mem
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdy, ddata, valid,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  proc_req, addr, wen, op2mem
    );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lsu_align : load lane extract/extend and sub-word store merge    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module lsu_align
    import lsu_pkg::*;
#(
    parameter int nbits = 32
) (
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [1:0]       lane_i,
    input  logic [nbits-1:0] rdata_i,
    input  logic [nbits-1:0] wdata_i,
    output logic [nbits-1:0] load_o,
    output logic [nbits-1:0] store_o
);

    logic [4:0]       w_byte_sh;
    logic [4:0]       w_half_sh;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [nbits-1:0] w_byte_mask;
    logic [nbits-1:0] w_half_mask;

    assign w_byte_sh   = {lane_i, 3'b000};
    assign w_half_sh   = {lane_i[1], 4'b0000};
    assign w_byte      = rdata_i[w_byte_sh +: 8];
    assign w_half      = rdata_i[w_half_sh +: 16];
    assign w_byte_mask = {{(nbits-8){1'b0}}, 8'hFF} << w_byte_sh;
    assign w_half_mask = {{(nbits-16){1'b0}}, 16'hFFFF} << w_half_sh;

    always_comb begin
        load_o  = rdata_i;
        store_o = wdata_i;
        case (size_i)
            SZ_B: begin
                load_o  = {{(nbits-8){w_byte[7] & ~unsigned_i}}, w_byte};
                store_o = (rdata_i & ~w_byte_mask)
                        | ({{(nbits-8){1'b0}}, wdata_i[7:0]} << w_byte_sh);
            end
            SZ_H: begin
                load_o  = {{(nbits-16){w_half[15] & ~unsigned_i}}, w_half};
                store_o = (rdata_i & ~w_half_mask)
                        | ({{(nbits-16){1'b0}}, wdata_i[15:0]} << w_half_sh);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_dmem_master.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lsu_dmem_master : single-outstanding load/store master with RMW  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter int nbits = 32
) (
    input  logic              clk,
    input  logic              rst,
    lsu_dmem_master_if.master bus
);

    lsu_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       lane_q, lane_d;
    logic [nbits-1:0] wdata_q, wdata_d;
    logic [nbits-1:0] addr_q, addr_d;
    logic             wen_q, wen_d;
    logic [nbits-1:0] op2mem_q, op2mem_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic [nbits-1:0] resp_rdata_q, resp_rdata_d;

    logic [nbits-1:0] w_load_ext;
    logic [nbits-1:0] w_store_word;

    lsu_align #(.nbits(nbits)) u_align (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .lane_i     (lane_q),
        .rdata_i    (bus.ddata),
        .wdata_i    (wdata_q),
        .load_o     (w_load_ext),
        .store_o    (w_store_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_W;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            addr_q       <= '0;
            wen_q        <= WEN_READ;
            op2mem_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            op2mem_q     <= op2mem_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        op2mem_d     = op2mem_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    lane_d  = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata;
                    if (access_illegal(bus.req_size, bus.req_addr[1:0])) begin
                        state_d = ERR;
                    end else begin
                        addr_d = {bus.req_addr[nbits-1:2], 2'b00};
                        // Only a full-word store can skip the read half of RMW.
                        if (bus.req_we && (bus.req_size == SZ_W)) begin
                            state_d  = WR_REQ;
                            wen_d    = WEN_WRITE;
                            op2mem_d = bus.req_wdata;
                        end else begin
                            state_d = RD_REQ;
                            wen_d   = WEN_READ;
                        end
                    end
                end
            end
            RD_REQ: begin
                if (bus.mem_rdy) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.valid) begin
                    if (we_q) begin
                        state_d  = WR_REQ;
                        wen_d    = WEN_WRITE;
                        op2mem_d = w_store_word;
                    end else begin
                        state_d      = IDLE;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = w_load_ext;
                    end
                end
            end
            WR_REQ: begin
                if (bus.mem_rdy) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (bus.valid) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                end
            end
            ERR: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.proc_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign bus.addr       = addr_q;
    assign bus.wen        = wen_q;
    assign bus.op2mem     = op2mem_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_master.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_lsu_dmem_master : vector table, corner sequences, random runs |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_lsu_dmem_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_dmem_master_if #(.nbits(32)) bus ();

    lsu_dmem_master #(.nbits(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word-addressed memory seen by the DUT, and the bench's own expectation of it.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    bit          rnd_mode    = 1'b0;
    int          force_stall = 0;
    int          fixed_delay = 0;
    int          hs_rd, hs_wr, req_hi_cnt, last_req_hi;
    logic        last_hs_wen;
    logic [31:0] last_hs_op;
    bit          pend = 1'b0;
    int          pdelay;
    logic [31:0] p_addr, p_wdata;
    logic        p_wen;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr, prev_op;
    logic        prev_wen;

    initial begin
        bus.mem_rdy = 1'b0;
        bus.valid   = 1'b0;
        bus.ddata   = '0;
        forever begin
            @(negedge clk);
            bus.valid = 1'b0;
            if (pend) begin
                if (pdelay == 0) begin
                    bus.valid = 1'b1;
                    if (p_wen) bus.ddata = mem[p_addr[9:2]];
                    else begin
                        mem[p_addr[9:2]] = p_wdata;
                        bus.ddata = $urandom;
                    end
                    pend = 1'b0;
                end else pdelay--;
            end else if (rnd_mode) begin
                bus.ddata = $urandom;
                bus.valid = ($urandom_range(0, 7) == 0);
            end
            if (bus.proc_req) begin
                req_hi_cnt++;
                if (prev_req) begin
                    chk("hold_addr", bus.addr, prev_addr);
                    chk("hold_op2mem", bus.op2mem, prev_op);
                    chk("hold_wen", {31'b0, bus.wen}, {31'b0, prev_wen});
                end
                if (force_stall > 0) begin
                    bus.mem_rdy = 1'b0;
                    force_stall--;
                end else bus.mem_rdy = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (bus.mem_rdy) begin
                    chk("hs_addr_align", {30'b0, bus.addr[1:0]}, 32'h0);
                    pend        = 1'b1;
                    pdelay      = rnd_mode ? int'($urandom_range(0, 3)) : fixed_delay;
                    p_addr      = bus.addr;
                    p_wen       = bus.wen;
                    p_wdata     = bus.op2mem;
                    last_hs_wen = bus.wen;
                    last_hs_op  = bus.op2mem;
                    if (bus.wen) hs_rd++; else hs_wr++;
                    last_req_hi = req_hi_cnt;
                    req_hi_cnt  = 0;
                end
            end else begin
                bus.mem_rdy = rnd_mode ? ($urandom_range(0, 1) != 0) : 1'b0;
                req_hi_cnt  = 0;
            end
            prev_req  = bus.proc_req && !bus.mem_rdy;
            prev_addr = bus.addr;
            prev_op   = bus.op2mem;
            prev_wen  = bus.wen;
        end
    end

    // Watches response pulse width and that resp_rdata holds between responses.
    int          dbl_pulse = 0;
    int          hold_viol = 0;
    int          resp_seen = 0;
    logic        prev_rv   = 1'b0;
    logic [31:0] held_rdata = '0;
    initial forever begin
        @(negedge clk);
        if (!rst) held_rdata = '0;
        else begin
            if (bus.resp_valid) begin
                resp_seen++;
                if (prev_rv) dbl_pulse++;
                held_rdata = bus.resp_rdata;
            end else if (bus.resp_rdata !== held_rdata) hold_viol++;
        end
        prev_rv = bus.resp_valid;
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int rdy_viol, output bit tmo);
        int guard = 0;
        tmo = 1'b0; rdy_viol = 0; lat = 0; rdata = '0; err = 1'b0;
        while (!bus.req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        hs_rd = 0;
        hs_wr = 0;
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        lat = 1;
        while (!bus.resp_valid && lat < 200) begin
            if (bus.req_ready) rdy_viol++;
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) tmo = 1'b1;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
    endtask

    // Reference model: access rules expressed as plain arithmetic on whole words.
    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (word >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else v = word;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] a,
                                              input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] mask, sh;
        if (size == 2'd2) return wd;
        sh   = (size == 2'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_mem;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] init,
                                input logic [31:0] er, input logic ee, input int el, input logic [31:0] em);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = a; v.wdata = wd; v.init = init;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_mem = em;
        return v;
    endfunction

    vec_t        tbl [14];
    logic [31:0] rd;
    logic        er;
    int          lat, rv;
    bit          tmo;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        //            we    sz    uns   addr          wdata         init          exp_rdata     err lat exp_mem
        tbl[0]  = mk(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 32'hFFFF_FF80, 0, 3, 32'h80FF_1234);
        tbl[1]  = mk(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_1234, 32'h0000_0080, 0, 3, 32'h80FF_1234);
        tbl[2]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h1111_2222, 32'h0,        0, 5, 32'hABCD_2222);
        tbl[3]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,        32'h5555_AAAA, 32'h0,        1, 2, 32'h5555_AAAA);
        tbl[4]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'h0,        32'h8001_7FFF, 32'h0000_7FFF, 0, 3, 32'h8001_7FFF);
        tbl[5]  = mk(1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 32'h0000_8001, 0, 3, 32'h8001_7FFF);
        tbl[6]  = mk(1'b1, 2'd2, 1'b0, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0,        32'h0,        0, 3, 32'hDEAD_BEEF);
        tbl[7]  = mk(1'b1, 2'd0, 1'b0, 32'h0000_0301, 32'h0000_00A5, 32'h1122_3344, 32'h0,        0, 5, 32'h1122_A544);
        tbl[8]  = mk(1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,        32'h0123_4567, 32'h0,        1, 2, 32'h0123_4567);
        tbl[9]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'hFFFF_FFFF, 32'h7777_7777, 32'h0,        1, 2, 32'h7777_7777);
        tbl[10] = mk(1'b0, 2'd2, 1'b0, 32'h0000_0208, 32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D, 0, 3, 32'hCAFE_F00D);
        tbl[11] = mk(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        32'h80FF_1234, 32'hFFFF_80FF, 0, 3, 32'h80FF_1234);
        tbl[12] = mk(1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'h0,        32'h80FF_1234, 32'h0000_0034, 0, 3, 32'h80FF_1234);
        tbl[13] = mk(1'b1, 2'd0, 1'b0, 32'h0000_0008, 32'hFFFF_FF77, 32'h0000_0000, 32'h0,        0, 5, 32'h0000_0077);

        repeat (3) @(negedge clk);
        chk("rst_proc_req", {31'b0, bus.proc_req}, 32'h0);
        chk("rst_wen", {31'b0, bus.wen}, 32'h1);
        chk("rst_addr", bus.addr, 32'h0);
        chk("rst_op2mem", bus.op2mem, 32'h0);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        #2 rst = 1'b1;
        #1 chk("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            logic [7:0] idx;
            logic       ok;
            idx = tbl[i].addr[9:2];
            mem[idx]     = tbl[i].init;
            ref_mem[idx] = tbl[i].init;
            ok = !tbl[i].exp_err;
            do_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, er, lat, rv, tmo);
            chk($sformatf("vec%0d_timeout", i), {31'b0, tmo}, 32'h0);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_ready_low", i), rv, 32'h0);
            chk($sformatf("vec%0d_mem", i), mem[idx], tbl[i].exp_mem);
            chk($sformatf("vec%0d_reads", i), hs_rd,
                (ok && !(tbl[i].we && tbl[i].size == 2'd2)) ? 32'h1 : 32'h0);
            chk($sformatf("vec%0d_writes", i), hs_wr, (ok && tbl[i].we) ? 32'h1 : 32'h0);
            ref_mem[idx] = tbl[i].exp_mem;
        end

        // Word store against a memory that holds off mem_rdy for three cycles.
        force_stall = 3;
        mem[8'h80] = 32'h0; ref_mem[8'h80] = 32'h0;
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, rd, er, lat, rv, tmo);
        chk("stall_timeout", {31'b0, tmo}, 32'h0);
        chk("stall_req_cycles", last_req_hi, 32'd4);
        chk("stall_wen", {31'b0, last_hs_wen}, 32'h0);
        chk("stall_op2mem", last_hs_op, 32'hDEAD_BEEF);
        chk("stall_latency", lat, 32'd6);
        chk("stall_mem", mem[8'h80], 32'hDEAD_BEEF);
        ref_mem[8'h80] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stall_single_pulse", {31'b0, bus.resp_valid}, 32'h0);

        // Reset while the load sits in RD_WAIT; the memory answers afterwards.
        fixed_delay = 2;
        resp_seen   = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0000_0040; bus.req_wdata = '0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_proc_req", {31'b0, bus.proc_req}, 32'h0);
        chk("midrst_wen", {31'b0, bus.wen}, 32'h1);
        chk("midrst_addr", bus.addr, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("midrst_ready", {31'b0, bus.req_ready}, 32'h1);
        repeat (5) @(negedge clk);
        chk("midrst_no_resp", resp_seen, 32'h0);
        chk("midrst_idle_ready", {31'b0, bus.req_ready}, 32'h1);
        chk("midrst_idle_proc_req", {31'b0, bus.proc_req}, 32'h0);
        fixed_delay = 0;

        rnd_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic        we, uns, eerr;
            logic [1:0]  sz;
            logic [31:0] a, wd, old, erd;
            int          r;
            r   = int'($urandom_range(0, 9));
            sz  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            a   = $urandom_range(0, 1023);
            wd  = $urandom;
            if ($urandom_range(0, 3) != 0) a = (sz == 2'd2) ? a & ~32'h3 : (sz == 2'd1) ? a & ~32'h1 : a;
            eerr = ref_err(sz, a);
            old  = ref_mem[a[9:2]];
            erd  = (eerr || we) ? 32'h0 : ref_load(old, a, sz, uns);
            if (!eerr && we) ref_mem[a[9:2]] = ref_store(old, a, sz, wd);
            do_req(we, sz, uns, a, wd, rd, er, lat, rv, tmo);
            chk($sformatf("rnd%0d_timeout", i), {31'b0, tmo}, 32'h0);
            chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, eerr});
            chk($sformatf("rnd%0d_ready_low", i), rv, 32'h0);
            chk($sformatf("rnd%0d_mem", i), mem[a[9:2]], ref_mem[a[9:2]]);
        end
        rnd_mode = 1'b0;
        repeat (6) @(negedge clk);

        chk("resp_pulse_width", dbl_pulse, 32'h0);
        chk("resp_rdata_hold", hold_viol, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
